// File: rtl/flop_test_sequencer.sv
// Sequencer for the configurable-latency flop datapath: programs num_clks, launches
// an arithmetic pattern run on flop_in, checks flop_out and reports pass/fail.
module flop_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CHECK_SLACK   = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      cfg_num_clks,
  input  logic [CNT_W-1:0] cfg_pat_count,
  input  logic [31:0]      cfg_seed,
  input  logic [31:0]      cfg_stride,
  output logic [31:0]      num_clks,
  output logic [31:0]      flop_in,
  input  logic [31:0]      flop_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             aborted,
  output logic             cfg_err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [31:0]      first_err_data
);

  localparam int unsigned DW = 32;
  localparam int unsigned WW = DW + 1;
  localparam int unsigned SW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_DRIVE, S_WAIT, S_CHECK, S_FINISH
  } state_e;

  state_e state_q, state_d;

  logic [SW-1:0]    settle_q, settle_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] pc_q, pc_d;
  logic [DW-1:0]    stride_q, stride_d;
  logic [DW-1:0]    pat_q, pat_d;
  logic [DW-1:0]    nc_q, nc_d;
  logic [DW-1:0]    fin_q, fin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             aborted_q, aborted_d;
  logic             cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] fe_idx_q, fe_idx_d;
  logic [DW-1:0]    fe_data_q, fe_data_d;

  logic cfg_bad_c;
  logic last_c;
  logic abortable_c;

  assign cfg_bad_c   = (cfg_num_clks == '0) || (cfg_pat_count == '0);
  assign last_c      = (idx_q == pc_q - CNT_W'(1));
  assign abortable_c = (state_q != S_IDLE) && (state_q != S_FINISH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = cfg_bad_c ? S_FINISH : S_SETUP;
      S_SETUP:  if (abort) state_d = S_FINISH;
                else if (settle_q == '0) state_d = S_DRIVE;
      S_DRIVE:  state_d = abort ? S_FINISH : S_WAIT;
      S_WAIT:   if (abort) state_d = S_FINISH;
                else if (wait_q == '0) state_d = S_CHECK;
      S_CHECK:  state_d = (abort || last_c) ? S_FINISH : S_DRIVE;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    settle_d  = settle_q;
    wait_d    = wait_q;
    idx_d     = idx_q;
    pc_d      = pc_q;
    stride_d  = stride_q;
    pat_d     = pat_q;
    nc_d      = nc_q;
    fin_d     = fin_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    aborted_d = aborted_q;
    cfg_err_d = cfg_err_q;
    err_d     = err_q;
    fe_idx_d  = fe_idx_q;
    fe_data_d = fe_data_q;
    case (state_q)
      S_IDLE: if (start) begin
        busy_d    = 1'b1;
        pass_d    = 1'b0;
        aborted_d = 1'b0;
        cfg_err_d = cfg_bad_c;
        err_d     = '0;
        fe_idx_d  = '0;
        fe_data_d = '0;
        idx_d     = '0;
        pc_d      = cfg_pat_count;
        stride_d  = cfg_stride;
        pat_d     = cfg_seed;
        settle_d  = SW'(SETTLE_CYCLES - 1);
        if (!cfg_bad_c) nc_d = cfg_num_clks;
      end
      S_SETUP: if (settle_q != '0) settle_d = settle_q - SW'(1);
      S_DRIVE: begin
        fin_d  = pat_q;
        wait_d = {1'b0, nc_q} + WW'(CHECK_SLACK) - WW'(1);
      end
      S_WAIT: if (wait_q != '0) wait_d = wait_q - WW'(1);
      S_CHECK: begin
        if (flop_out != fin_q) begin
          if (err_q != '1) err_d = err_q + CNT_W'(1);
          if (err_q == '0) begin
            fe_idx_d  = idx_q;
            fe_data_d = flop_out;
          end
        end
        if (!last_c) begin
          idx_d = idx_q + CNT_W'(1);
          pat_d = pat_q + stride_q;
        end
      end
      S_FINISH: busy_d = 1'b0;
      default: ;
    endcase
    if (abort && abortable_c) aborted_d = 1'b1;
    // done and pass are raised on entry so they are visible during FINISH itself
    if (state_d == S_FINISH && state_q != S_FINISH) begin
      done_d = 1'b1;
      pass_d = (err_d == '0) && !aborted_d && !cfg_err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_q  <= '0;
      wait_q    <= '0;
      idx_q     <= '0;
      pc_q      <= '0;
      stride_q  <= '0;
      pat_q     <= '0;
      nc_q      <= '0;
      fin_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      aborted_q <= 1'b0;
      cfg_err_q <= 1'b0;
      err_q     <= '0;
      fe_idx_q  <= '0;
      fe_data_q <= '0;
    end else begin
      settle_q  <= settle_d;
      wait_q    <= wait_d;
      idx_q     <= idx_d;
      pc_q      <= pc_d;
      stride_q  <= stride_d;
      pat_q     <= pat_d;
      nc_q      <= nc_d;
      fin_q     <= fin_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      aborted_q <= aborted_d;
      cfg_err_q <= cfg_err_d;
      err_q     <= err_d;
      fe_idx_q  <= fe_idx_d;
      fe_data_q <= fe_data_d;
    end
  end

  assign num_clks       = nc_q;
  assign flop_in        = fin_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign aborted        = aborted_q;
  assign cfg_err        = cfg_err_q;
  assign err_count      = err_q;
  assign first_err_idx  = fe_idx_q;
  assign first_err_data = fe_data_q;

endmodule

// File: doc/flop_test_sequencer.md
Name: flop_test_sequencer

Overview:
- Controller that sequences the 32-bit configurable-latency flop datapath (clk, num_clks, flop_in, flop_out).
- Programs num_clks, launches a run of deterministic patterns on flop_in one at a time, and samples flop_out after the programmed latency.
- Compares each sample against the launched pattern and reports pass/fail plus first-error capture.
- Sits beside the flop datapath in the floptest environment, replacing per-pattern testbench sequencing.

Parameters:
- SETTLE_CYCLES, 2, idle cycles after num_clks is programmed before the first launch.
- CHECK_SLACK, 1, extra cycles beyond num_clks before flop_out is sampled.
- CNT_W, 16, width of the pattern-count, error-count and index fields.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- abort  input  1  terminate the run at the next edge.
- cfg_num_clks  input  32  datapath latency to program; sampled at start.
- cfg_pat_count  input  CNT_W  number of patterns to run; sampled at start.
- cfg_seed  input  32  first pattern value.
- cfg_stride  input  32  pattern increment.
- num_clks  output  32  latency configuration driven to the datapath.
- flop_in  output  32  pattern driven to the datapath.
- flop_out  input  32  datapath output.
- busy  output  1  high from start acceptance until done.
- done  output  1  single-cycle completion pulse.
- pass  output  1  valid at done and held until next start; 1 when err_count==0, not aborted and no cfg_err.
- aborted  output  1  run ended by abort; held until next start.
- cfg_err  output  1  illegal config; held until next start.
- err_count  output  CNT_W  mismatches in the run; saturates at all-ones.
- first_err_idx  output  CNT_W  pattern index of the first mismatch.
- first_err_data  output  32  flop_out value at the first mismatch.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; num_clks=0; flop_in=0.
- Reset asserted mid-run aborts immediately with no done pulse.
- FSM states: IDLE, SETUP, DRIVE, WAIT, CHECK, FINISH.
- IDLE, start=1:
  - Latch all cfg_* inputs; clear err_count, first_err_*, pass, aborted, cfg_err; busy=1.
  - If cfg_num_clks==0 or cfg_pat_count==0: set cfg_err=1 and go to FINISH.
  - Otherwise go to SETUP.
- SETUP:
  - num_clks is driven with the latched latency and held constant for the whole run.
  - Stay SETTLE_CYCLES cycles, then go to DRIVE.
- DRIVE (1 cycle):
  - flop_in <= seed + idx*stride, mod 2^32; idx starts at 0.
  - Load the wait counter with num_clks+CHECK_SLACK-1; go to WAIT.
- WAIT:
  - Decrement the counter; at 0, go to CHECK.
  - flop_in is held constant throughout.
  - flop_out is therefore sampled exactly num_clks+CHECK_SLACK cycles after the edge that updated flop_in.
  - Counter arithmetic is 33 bits, so num_clks=0xFFFFFFFF does not wrap.
- CHECK (1 cycle):
  - On flop_out != flop_in: err_count++ (saturating).
  - On the first mismatch: capture first_err_idx=idx and first_err_data=flop_out.
  - If idx==pat_count-1, go to FINISH; otherwise idx++ and go to DRIVE.
- FINISH (1 cycle):
  - done=1, busy=0 on the following cycle, pass computed; return to IDLE.
  - num_clks and flop_in keep their last values.
- Start handling: start while not in IDLE is ignored. start and done in the same cycle: start is ignored, because the FSM is not yet in IDLE.
- abort:
  - Any state except IDLE and FINISH goes to FINISH with aborted=1.
  - abort in IDLE has no effect.
  - abort coinciding with a CHECK compare: that compare is still counted.
- Pattern arithmetic wraps modulo 2^32 with no flag.

Test Plan:
- Single pattern: cfg_num_clks=3, pat_count=1, seed=0xA5A5A5A5, stride=0, correct DUT -> flop_in=0xA5A5A5A5; done 2+1+4+1+1 cycles after start; pass=1, err_count=0.
- Multi-pattern: num_clks=5, pat_count=4, seed=0x10, stride=0x10 -> flop_in sequence 0x10,0x20,0x30,0x40; pass=1.
- Fault injection: flop_out forced to 0xDEADBEEF during the 3rd pattern of 4 (seed=0, stride=1) -> err_count=1, first_err_idx=2, first_err_data=0xDEADBEEF, pass=0.
- Config errors: num_clks=0 -> cfg_err=1, done within 2 cycles, flop_in never changes. Separately, pat_count=0 -> cfg_err=1.
- Wrap and latency extreme: seed=0xFFFFFFFF, stride=1, pat_count=2, num_clks=1 -> patterns 0xFFFFFFFF then 0x00000000, pass=1.
- Abort/reset: abort during WAIT of pattern 1 -> done pulse, aborted=1, pass=0. Reset asserted mid-WAIT -> all outputs 0 asynchronously, no done pulse. start while busy -> ignored, run completes unchanged.
